// File: rtl/multi_lane_traffic_sensor.sv
// Multi-lane pseudo-random traffic sensor: N_LANES Fibonacci LFSRs sharing one
// step counter, with a registered per-lane car-present threshold compare.
module multi_lane_traffic_sensor #(
  parameter int unsigned       N_LANES = 2,
  parameter int unsigned       WIDTH   = 5,
  parameter logic [WIDTH-1:0]  SEED    = WIDTH'(5'b10101)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load,
  input  logic [WIDTH-1:0]           seed,
  input  logic [WIDTH-1:0]           threshold,
  output logic [N_LANES*WIDTH-1:0]   T,
  output logic [N_LANES-1:0]         car_present,
  output logic                       wrap
);

  // Maximal-length tap masks (bit n set = state[n] feeds the XOR).
  localparam logic [7:0] TAPS8 =
    (WIDTH == 4) ? 8'b0000_1100 :
    (WIDTH == 5) ? 8'b0001_0100 :
    (WIDTH == 6) ? 8'b0011_0000 :
    (WIDTH == 7) ? 8'b0110_0000 :
                   8'b1011_1000;
  localparam logic [WIDTH-1:0] TAPS     = TAPS8[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_ADV,
    OP_LOAD
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_d;
  logic [WIDTH-1:0] lane_q [N_LANES];
  logic [WIDTH-1:0] lane_d [N_LANES];

  function automatic logic [WIDTH-1:0] start_of(input logic [WIDTH-1:0] b,
                                                input int unsigned      i);
    logic [WIDTH-1:0] v;
    v = b ^ WIDTH'(i);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  always_comb begin
    op = OP_HOLD;
    if (load)    op = OP_LOAD;
    else if (en) op = OP_ADV;
  end

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      lane_d[i] = lane_q[i];
    end
    unique case (op)
      OP_LOAD: begin
        base_d = seed;
        cnt_d  = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
          lane_d[i] = start_of(seed, i);
        end
      end
      OP_ADV: begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
        wrap_d = (cnt_q == CNT_LAST);
        // A zeroed lane (upset) restarts from its start value instead of locking up.
        for (int unsigned i = 0; i < N_LANES; i++) begin
          lane_d[i] = (lane_q[i] == '0) ? start_of(base_q, i) : lfsr_step(lane_q[i]);
        end
      end
      OP_HOLD: begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
          if (lane_q[i] == '0) lane_d[i] = start_of(base_q, i);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= SEED;
      cnt_q       <= '0;
      wrap        <= 1'b0;
      car_present <= '0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lane_q[i] <= start_of(SEED, i);
      end
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      wrap   <= wrap_d;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lane_q[i]      <= lane_d[i];
        car_present[i] <= (lane_q[i] >= threshold);
      end
    end
  end

  always_comb begin
    T = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      T[i*WIDTH +: WIDTH] = lane_q[i];
    end
  end

endmodule
